// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, default width.
// Latency: n/a (package only).
// Backpressure: n/a.
// Optional feature macro used by the design files: SEQ_ALU_DIV_EN (enables DIV/DIVU).
package alu_pkg;

   localparam int ALU_WIDTH_DEF = 32;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_MULT  = 4'b1000;
   localparam logic [3:0] ALU_MULTU = 4'b1001;
   localparam logic [3:0] ALU_DIV   = 4'b1010;
   localparam logic [3:0] ALU_DIVU  = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } alu_state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply / divide engine: one shift-add or restoring shift-subtract step per cycle.
// Latency: WIDTH steps after load_i; results valid combinationally from the final registers.
// Backpressure: none; the parent FSM alone decides when to load and when to step.
// Ports: clk/rst, load_i (capture operands), calc_i (perform one step), is_div_i/signed_i (op class),
//        src1_i/src2_i (operands), last_o (final step in progress), hi_o/lo_o (sign-corrected result),
//        is_div_o/div_zero_o (class and divide-by-zero of the loaded op).
// Macro: SEQ_ALU_DIV_EN includes the restoring divider; without it only multiply is built.
module seq_alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             calc_i,
   input  logic             is_div_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             last_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             is_div_o,
   output logic             div_zero_o
);

   localparam int CW = $clog2(WIDTH + 1);

   // acc holds {upper, lower}: product for multiply, {remainder, quotient} for divide.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               dz_q, dz_d;
   logic               neg_q_q, neg_q_d;   // negate product / quotient

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod_fix;

   assign a_neg = signed_i & src1_i[WIDTH-1];
   assign b_neg = signed_i & src2_i[WIDTH-1];
   assign a_mag = a_neg ? -src1_i : src1_i;
   assign b_mag = b_neg ? -src2_i : src2_i;

   // Shift-add: conditionally add the multiplicand into the upper half, then shift right with carry.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   assign prod_fix = neg_q_q ? -acc_q : acc_q;

`ifdef SEQ_ALU_DIV_EN
   logic               neg_r_q, neg_r_d;   // remainder follows the dividend sign
   logic [WIDTH-1:0]   dividend_q, dividend_d;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_trial;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   quo, rem;

   // Restoring step: shift next dividend bit into the remainder, keep the subtraction if it did not borrow.
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
   assign div_ge    = ~div_trial[WIDTH+1];
   assign div_next  = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};
   assign quo = acc_q[WIDTH-1:0];
   assign rem = acc_q[2*WIDTH-1:WIDTH];
`endif

   always_comb begin
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      dz_d     = dz_q;
      neg_q_d  = neg_q_q;
`ifdef SEQ_ALU_DIV_EN
      neg_r_d    = neg_r_q;
      dividend_d = dividend_q;
`endif
      if (load_i) begin
         cnt_d    = '0;
         is_div_d = is_div_i;
         dz_d     = is_div_i && (src2_i == '0);
         neg_q_d  = a_neg ^ b_neg;
         acc_d    = {{WIDTH{1'b0}}, b_mag};
         opnd_d   = a_mag;
`ifdef SEQ_ALU_DIV_EN
         neg_r_d    = a_neg;
         dividend_d = src1_i;
         if (is_div_i) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
         end
`endif
      end else if (calc_i) begin
         cnt_d = cnt_q + CW'(1);
         acc_d = mul_next;
`ifdef SEQ_ALU_DIV_EN
         if (is_div_q) acc_d = div_next;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
         neg_q_q  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         neg_r_q    <= 1'b0;
         dividend_q <= '0;
`endif
      end else begin
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
         neg_q_q  <= neg_q_d;
`ifdef SEQ_ALU_DIV_EN
         neg_r_q    <= neg_r_d;
         dividend_q <= dividend_d;
`endif
      end
   end

   always_comb begin
      hi_o = prod_fix[2*WIDTH-1:WIDTH];
      lo_o = prod_fix[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
      // Divide by zero reports the raw dividend and an all-ones quotient, regardless of sign.
      if (is_div_q) begin
         lo_o = dz_q ? '1 : (neg_q_q ? -quo : quo);
         hi_o = dz_q ? dividend_q : (neg_r_q ? -rem : rem);
      end
`endif
   end

   assign last_o     = (cnt_q == CW'(WIDTH - 1));
   assign is_div_o   = is_div_q;
   assign div_zero_o = dz_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative mul/div into HI/LO.
// Latency: single-cycle ops 1 edge; MULT/MULTU/DIV/DIVU WIDTH+1 edges.
// Backpressure: busy high while an iterative op runs; start is ignored (not queued) while busy.
// Ports: clk, rst (async, active high), start/alu_control/src1/src2 (request), busy, done (1-cycle pulse),
//        result/zero/overflow (single-cycle op outputs), hi/lo/div_zero (iterative op outputs).
// Macro: SEQ_ALU_DIV_EN enables DIV/DIVU; otherwise they act as unknown opcodes.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH      = ALU_WIDTH_DEF,
   parameter int CTRL_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CTRL_WIDTH-1:0] alu_control,
   input  logic [WIDTH-1:0]      src1,
   input  logic [WIDTH-1:0]      src2,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      result,
   output logic                  zero,
   output logic                  overflow,
   output logic [WIDTH-1:0]      hi,
   output logic [WIDTH-1:0]      lo,
   output logic                  div_zero
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             zero_q, zero_d;
   logic             overflow_q, overflow_d;
   logic             div_zero_q, div_zero_d;
   logic             done_q, done_d;

   logic             accept;
   logic             is_mul, is_div_op, is_multi, is_signed;
   logic             load;
   logic [WIDTH-1:0] sum, diff;
   logic             eng_last, eng_is_div, eng_dz;
   logic [WIDTH-1:0] eng_hi, eng_lo;

   assign busy   = (state_q != ST_IDLE);
   assign accept = start && !busy;

   assign is_mul = (alu_control == CTRL_WIDTH'(ALU_MULT)) || (alu_control == CTRL_WIDTH'(ALU_MULTU));
`ifdef SEQ_ALU_DIV_EN
   assign is_div_op = (alu_control == CTRL_WIDTH'(ALU_DIV)) || (alu_control == CTRL_WIDTH'(ALU_DIVU));
   assign is_signed = (alu_control == CTRL_WIDTH'(ALU_MULT)) || (alu_control == CTRL_WIDTH'(ALU_DIV));
`else
   assign is_div_op = 1'b0;
   assign is_signed = (alu_control == CTRL_WIDTH'(ALU_MULT));
`endif
   assign is_multi = is_mul || is_div_op;

   assign sum  = src1 + src2;
   assign diff = src1 - src2;

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .calc_i     (state_q == ST_CALC),
      .is_div_i   (is_div_op),
      .signed_i   (is_signed),
      .src1_i     (src1),
      .src2_i     (src2),
      .last_o     (eng_last),
      .hi_o       (eng_hi),
      .lo_o       (eng_lo),
      .is_div_o   (eng_is_div),
      .div_zero_o (eng_dz)
   );

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      load       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_multi) begin
                  load    = 1'b1;
                  state_d = ST_CALC;
               end else begin
                  done_d     = 1'b1;
                  zero_d     = (src1 == src2);
                  overflow_d = 1'b0;
                  result_d   = '0;
                  case (alu_control)
                     CTRL_WIDTH'(ALU_AND): result_d = src1 & src2;
                     CTRL_WIDTH'(ALU_OR):  result_d = src1 | src2;
                     CTRL_WIDTH'(ALU_ADD): begin
                        result_d   = sum;
                        // Like-signed operands producing an opposite-signed sum.
                        overflow_d = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
                     end
                     CTRL_WIDTH'(ALU_SUB): begin
                        result_d   = diff;
                        overflow_d = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
                     end
                     CTRL_WIDTH'(ALU_SLT): result_d = WIDTH'($signed(src1) < $signed(src2));
                     default: result_d = '0;
                  endcase
               end
            end
         end
         ST_CALC: begin
            if (eng_last) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            hi_d    = eng_hi;
            lo_d    = eng_lo;
            if (eng_is_div) div_zero_d = eng_dz;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         result_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
      end
   end

   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); DIV expectations follow SEQ_ALU_DIV_EN.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  alu_control;
   logic [31:0] src1, src2;
   logic        busy, done, zero, overflow, div_zero;
   logic [31:0] result, hi, lo;

   int n_chk = 0;
   int n_err = 0;

   seq_alu #(.WIDTH(32), .CTRL_WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .alu_control (alu_control),
      .src1        (src1),
      .src2        (src2),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .hi          (hi),
      .lo          (lo),
      .div_zero    (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request before the edge; returns 1ns after the accepting edge.
   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      alu_control = op;
      src1        = a;
      src2        = b;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after acceptance until done; optionally pokes an ADD request while busy.
   task automatic wait_done(input bit poke, output int n, output bit busy_ok);
      n       = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && n < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
         if (poke && n == 5) begin
            alu_control = ALU_ADD;
            src1        = 32'd1;
            src2        = 32'd1;
            start       = 1'b1;
         end
         if (poke && n == 6) start = 1'b0;
      end
   endtask

   initial begin
      int n;
      bit bok;
      bit seen;
      rst = 1'b1; start = 1'b0; alu_control = '0; src1 = '0; src2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 0);
      check("rst_ovf", overflow, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_dz", div_zero, 0);
      @(negedge clk);
      rst = 1'b0;

      // ADD overflow, single-cycle timing
      start_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
      check("add_done", done, 1);
      check("add_busy", busy, 0);
      check("add_res", result, 64'h8000_0000);
      check("add_ovf", overflow, 1);
      check("add_zero", zero, 0);

      // Back-to-back single ops on consecutive cycles
      start_op(ALU_SLT, 32'hFFFF_FFFB, 32'd3);
      check("slt_done", done, 1);
      check("slt_res", result, 1);
      check("slt_ovf", overflow, 0);
      start_op(ALU_SUB, 32'd7, 32'd7);
      check("sub_res", result, 0);
      check("sub_zero", zero, 1);
      check("sub_ovf", overflow, 0);
      start_op(ALU_SUB, 32'h8000_0000, 32'd1);
      check("subov_res", result, 64'h7FFF_FFFF);
      check("subov_ovf", overflow, 1);
      start_op(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
      check("and_res", result, 64'hF000);
      start_op(ALU_OR, 32'h0000_F0F0, 32'h0000_FF00);
      check("or_res", result, 64'hFFF0);
      start_op(4'b0011, 32'd5, 32'd5);
      check("unk_done", done, 1);
      check("unk_res", result, 0);
      @(posedge clk);
      #1;
      check("unk_done_drop", done, 0);

      // MULT with an ignored ADD poked mid-calc
      start_op(ALU_MULT, 32'hFFFF_FFFD, 32'd4);
      check("mult_busy", busy, 1);
      check("mult_done0", done, 0);
      wait_done(1'b1, n, bok);
      check("mult_lat", n, 33);
      check("mult_busyhold", bok, 1);
      check("mult_hi", hi, 64'hFFFF_FFFF);
      check("mult_lo", lo, 64'hFFFF_FFF4);
      check("mult_busy_end", busy, 0);
      check("mult_res_keep", result, 0);

      // New start in the done cycle
      start_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_acc", busy, 1);
      wait_done(1'b0, n, bok);
      check("multu_lat", n, 33);
      check("multu_hi", hi, 64'hFFFF_FFFE);
      check("multu_lo", lo, 64'h1);

`ifdef SEQ_ALU_DIV_EN
      start_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(1'b0, n, bok);
      check("div_lat", n, 33);
      check("div_lo", lo, 64'hFFFF_FFFD);
      check("div_hi", hi, 64'hFFFF_FFFF);
      check("div_dz", div_zero, 0);
      start_op(ALU_DIVU, 32'd10, 32'd0);
      wait_done(1'b0, n, bok);
      check("divz_lat", n, 33);
      check("divz_lo", lo, 64'hFFFF_FFFF);
      check("divz_hi", hi, 64'd10);
      check("divz_dz", div_zero, 1);
      start_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1'b0, n, bok);
      check("divmin_lo", lo, 64'h8000_0000);
      check("divmin_hi", hi, 0);
      check("divmin_dz", div_zero, 0);
`else
      start_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
      check("nodiv_done", done, 1);
      check("nodiv_busy", busy, 0);
      check("nodiv_res", result, 0);
      check("nodiv_hi", hi, 64'hFFFF_FFFE);
      check("nodiv_lo", lo, 64'h1);
      check("nodiv_dz", div_zero, 0);
`endif

      // Reset mid-CALC aborts with no done
      start_op(ALU_MULT, 32'd5, 32'd6);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_hi", hi, 0);
      check("arst_lo", lo, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      check("arst_nodone", seen, 0);
      check("arst_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the single-cycle datapath ALU for the MIPS core. It executes the single-cycle integer ops (ADD/SUB/AND/OR/SLT) with one-cycle registered latency. It also executes iterative signed/unsigned multiply and divide into HI/LO registers over a start/busy/done handshake. It sits in EX, and the core stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be ≥ 4.
- `CTRL_WIDTH`, 4, width of `alu_control`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `alu_control`  in  CTRL_WIDTH  opcode, sampled with `start`.
- `src1`, `src2`  in  WIDTH  operands, sampled with `start`.
- `busy`  out  1  multi-cycle op in progress.
- `done`  out  1  one-cycle pulse: outputs of the accepted op are valid.
- `result`  out  WIDTH  single-cycle op result (registered).
- `zero`  out  1  registered (`src1`==`src2`) of the last single-cycle op.
- `overflow`  out  1  signed overflow of the last ADD/SUB; 0 for all other ops.
- `hi`, `lo`  out  WIDTH each  MULT: high/low product; DIV: remainder/quotient.
- `div_zero`  out  1  last DIV/DIVU had `src2`=0.

## Operation
- Opcodes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (signed), MULT 1000, MULTU 1001, DIV 1010, DIVU 1011. Any other code gives `result`=0 and a single-cycle `done`.
- Single-cycle ops update `result`, `zero`, `overflow` and leave `hi`/`lo` unchanged. Multi-cycle ops leave `result`/`zero`/`overflow` unchanged.
- ADD/SUB wrap modulo 2^WIDTH. Overflow is set when the operand signs make the result sign impossible.
- FSM: IDLE → CALC (on an accepted multi-cycle `start`) → FINISH → IDLE.
  - CALC runs exactly WIDTH iterations: shift-add for multiply, restoring shift-subtract for divide.
  - Signed ops work on magnitudes. FINISH applies sign correction and writes `hi`/`lo`.
- Signed divide truncates toward zero. The remainder takes the dividend's sign.
- MIN/−1 gives `lo`=MIN, `hi`=0, no flag.
- Divide by zero still takes full latency. It gives `lo`=all ones, `hi`=`src1`, `div_zero`=1. Any other DIV/DIVU clears `div_zero`.
- `start` while `busy`=1 is ignored: no queueing, operands are not resampled.
- Operands are captured at acceptance. Changing `src1`/`src2` during CALC has no effect.

## Timing
- Reset (asynchronous) sets:
  - state to IDLE;
  - `busy`, `done`, `zero`, `overflow`, `div_zero` to 0;
  - `result`, `hi`, `lo` to 0.
- Reset mid-operation aborts the op. No `done` is produced.
- Single-cycle op: accepted on edge E0; `result`/flags and `done`=1 are valid after E0, for one cycle. `busy` stays 0, so back-to-back starts on consecutive cycles are allowed.
- Multi-cycle op: accepted on edge E0.
  - `busy`=1 from after E0 until edge E0+WIDTH+1.
  - After E0+WIDTH+1: `hi`/`lo` are valid, `done`=1 for one cycle, `busy`=0. Latency is WIDTH+1 edges.
- A new `start` is accepted in the same cycle that `done` is high.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIV/DIVU are implemented as above.
- `SEQ_ALU_DIV_EN` undefined: the divider logic is removed, and DIV/DIVU behave as unknown opcodes (single-cycle `done`, `result`=0, `hi`/`lo`/`div_zero` unchanged).

## Structure
- Shared package `alu_pkg`: opcode constants (`ALU_AND` … `ALU_DIVU`), FSM state typedef, default WIDTH.
- One sub-module, `seq_alu_muldiv`. It holds the iterative engine: counter, partial remainder/product, sign fix-up.
- The top level holds the single-cycle ops, handshake and output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 → `result`=0x80000000, `overflow`=1, `done` one cycle after start, `busy` never high.
- SLT −5 vs 3 → `result`=1. SUB 7−7 → `result`=0, `zero`=1.
- MULT −3 × 4 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF4, `done` exactly 33 edges after acceptance. MULTU 0xFFFFFFFF² → `hi`=0xFFFFFFFE, `lo`=1.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 10 / 0 → `lo`=0xFFFFFFFF, `hi`=10, `div_zero`=1.
- `start` pulsed with ADD during a busy MULT → ignored, `result` unchanged. A new `start` in the `done` cycle is accepted.
- `rst` asserted mid-CALC → `busy`=0 and `hi`/`lo`=0 immediately, no `done`. With `SEQ_ALU_DIV_EN` undefined, DIV → single-cycle `done`, `result`=0.
